// File: rtl/plot_receiver.sv
// Pixel-plot receiver: queues plot requests in a FIFO, clips them to the screen and
// writes each surviving pixel into a single-port framebuffer using a write/ready handshake.
module plot_receiver #(
    parameter int SCREEN_W   = 160,
    parameter int SCREEN_H   = 120,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 15,
    parameter int COLOUR_W   = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [9:0]          x,
    input  logic [9:0]          y,
    input  logic [COLOUR_W-1:0] colour,
    input  logic                writeEn,
    output logic                busy,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [COLOUR_W-1:0] mem_data,
    output logic                mem_wren,
    input  logic                mem_ready,
    output logic [3:0]          pending,
    output logic [15:0]         clip_count,
    output logic [15:0]         overflow_count
);

    localparam int XW    = $clog2(SCREEN_W);
    localparam int YW    = $clog2(SCREEN_H);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int EW    = XW + YW + COLOUR_W;

    localparam logic [9:0]     X_LIM    = 10'(SCREEN_W);
    localparam logic [9:0]     Y_LIM    = 10'(SCREEN_H);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_WRITE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [EW-1:0]       r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W:0]      r_count;
    logic [XW-1:0]       r_hold_x;
    logic [YW-1:0]       r_hold_y;
    logic [COLOUR_W-1:0] r_hold_c;
    logic [ADDR_W-1:0]   r_mem_address;
    logic [COLOUR_W-1:0] r_mem_data;
    logic [15:0]         r_clip_count;
    logic [15:0]         r_overflow_count;

    logic          w_clip;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_head;

    assign w_clip  = (x >= X_LIM) || (y >= Y_LIM);
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = writeEn && !w_clip && !w_full;
    assign w_head  = r_fifo[r_rd_ptr];

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {x[XW-1:0], y[YW-1:0], colour};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_pop    = 1'b0;
        mem_wren = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = S_ADDR;
                end
            end
            S_ADDR: begin
                w_next = S_WRITE;
            end
            S_WRITE: begin
                mem_wren = 1'b1;
                if (mem_ready) begin
                    if (!w_empty) begin
                        w_pop  = 1'b1;
                        w_next = S_ADDR;
                    end else begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_x      <= '0;
            r_hold_y      <= '0;
            r_hold_c      <= '0;
            r_mem_address <= '0;
            r_mem_data    <= '0;
        end else begin
            if (w_pop) begin
                r_hold_x <= w_head[EW-1 -: XW];
                r_hold_y <= w_head[COLOUR_W+YW-1 -: YW];
                r_hold_c <= w_head[COLOUR_W-1:0];
            end
            // Coordinates are already clipped, so the product always fits ADDR_W.
            if (r_state == S_ADDR) begin
                r_mem_address <= ADDR_W'(r_hold_y) * ADDR_W'(SCREEN_W) + ADDR_W'(r_hold_x);
                r_mem_data    <= r_hold_c;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clip_count     <= '0;
            r_overflow_count <= '0;
        end else if (writeEn) begin
            if (w_clip) begin
                if (r_clip_count != 16'hFFFF) begin
                    r_clip_count <= r_clip_count + 16'd1;
                end
            end else if (w_full) begin
                if (r_overflow_count != 16'hFFFF) begin
                    r_overflow_count <= r_overflow_count + 16'd1;
                end
            end
        end
    end

    assign busy           = w_full;
    assign mem_address    = r_mem_address;
    assign mem_data       = r_mem_data;
    assign pending        = 4'(r_count) + {3'b000, (r_state != S_IDLE)};
    assign clip_count     = r_clip_count;
    assign overflow_count = r_overflow_count;

endmodule

// File: tb/tb_plot_receiver.sv
// Self-checking bench for plot_receiver: a transaction-level model (expected-write queue,
// in-flight count, counters) checked every cycle, plus directed literal checks.
module tb_plot_receiver;

    logic        clk;
    logic        reset;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  colour;
    logic        writeEn;
    logic        busy;
    logic [14:0] mem_address;
    logic [2:0]  mem_data;
    logic        mem_wren;
    logic        mem_ready;
    logic [3:0]  pending;
    logic [15:0] clip_count;
    logic [15:0] overflow_count;

    plot_receiver dut (
        .clk            (clk),
        .reset          (reset),
        .x              (x),
        .y              (y),
        .colour         (colour),
        .writeEn        (writeEn),
        .busy           (busy),
        .mem_address    (mem_address),
        .mem_data       (mem_data),
        .mem_wren       (mem_wren),
        .mem_ready      (mem_ready),
        .pending        (pending),
        .clip_count     (clip_count),
        .overflow_count (overflow_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_writes = 0;

    // Model: expected writes in plot order; in-flight = accepted plots not yet written.
    int exp_q[$];
    int m_inflight = 0;
    int m_clip = 0;
    int m_ovf  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_inflight = 0;
            m_clip = 0;
            m_ovf  = 0;
        end else begin
            bit full_now;
            chk("pending", int'(pending), m_inflight);
            chk("busy", int'(busy), (m_inflight == 9) ? 1 : 0);
            chk("clip_count", int'(clip_count), m_clip);
            chk("overflow_count", int'(overflow_count), m_ovf);
            full_now = (m_inflight == 9);
            if (mem_wren && mem_ready) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    chk("write_addr", int'(mem_address), e >> 3);
                    chk("write_data", int'(mem_data), e & 7);
                    m_inflight--;
                end
            end
            if (writeEn) begin
                if (x >= 160 || y >= 120) begin
                    if (m_clip < 65535) m_clip++;
                end else if (full_now) begin
                    if (m_ovf < 65535) m_ovf++;
                end else begin
                    exp_q.push_back(((int'(y) * 160 + int'(x)) << 3) | int'(colour));
                    m_inflight++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic plot(input int px, input int py, input int pc);
        x = 10'(px);
        y = 10'(py);
        colour = 3'(pc);
        writeEn = 1'b1;
        tick();
        writeEn = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && pending != 0; i++) tick();
        chk("drain_timeout", int'(pending), 0);
    endtask

    logic        wr_seen [8];
    int          ad_seen [8];
    int          dt_seen [8];
    int          w0;

    initial begin
        reset = 1'b1;
        x = '0; y = '0; colour = '0; writeEn = 1'b0; mem_ready = 1'b1;
        #1;
        chk("rst_wren", int'(mem_wren), 0);
        chk("rst_addr", int'(mem_address), 0);
        chk("rst_data", int'(mem_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pending", int'(pending), 0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Single plot: write window is between edges N+2 and N+3
        plot(5, 3, 5);
        @(negedge clk); chk("t1_wren_n0", int'(mem_wren), 0);
        chk("t1_pending_n0", int'(pending), 1);
        @(negedge clk); chk("t1_wren_n1", int'(mem_wren), 0);
        @(negedge clk); chk("t1_wren_n2", int'(mem_wren), 1);
        chk("t1_addr", int'(mem_address), 485);
        chk("t1_data", int'(mem_data), 5);
        @(negedge clk); chk("t1_wren_n3", int'(mem_wren), 0);
        chk("t1_pending_end", int'(pending), 0);
        chk("t1_clip", int'(clip_count), 0);
        chk("t1_ovf", int'(overflow_count), 0);
        tick();

        // Back-to-back corner pixels
        plot(159, 119, 2);
        plot(0, 0, 7);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wr_seen[i] = mem_wren;
            ad_seen[i] = int'(mem_address);
            dt_seen[i] = int'(mem_data);
        end
        chk("t2_wren0", int'(wr_seen[0]), 0);
        chk("t2_wren1", int'(wr_seen[1]), 1);
        chk("t2_addr1", ad_seen[1], 19199);
        chk("t2_data1", dt_seen[1], 2);
        chk("t2_wren2", int'(wr_seen[2]), 0);
        chk("t2_wren3", int'(wr_seen[3]), 1);
        chk("t2_addr3", ad_seen[3], 0);
        chk("t2_data3", dt_seen[3], 7);
        chk("t2_wren4", int'(wr_seen[4]), 0);
        tick();
        drain();

        // Clipping on each axis, then a valid pixel
        w0 = n_writes;
        plot(160, 0, 1);
        plot(0, 120, 1);
        repeat (5) tick();
        chk("t3_no_write", n_writes - w0, 0);
        chk("t3_clip", int'(clip_count), 2);
        chk("t3_ovf", int'(overflow_count), 0);
        plot(10, 10, 4);
        for (int i = 0; i < 20 && !mem_wren; i++) tick();
        chk("t3_wren", int'(mem_wren), 1);
        chk("t3_addr", int'(mem_address), 1610);
        drain();

        // Backpressure: ten plots against a stalled memory
        mem_ready = 1'b0;
        w0 = n_writes;
        for (int i = 0; i < 10; i++) plot(20 + i, 2 * i, i % 8);
        chk("t4_busy", int'(busy), 1);
        chk("t4_pending", int'(pending), 9);
        chk("t4_ovf", int'(overflow_count), 1);
        mem_ready = 1'b1;
        @(negedge clk); chk("t4_busy_pre_pop", int'(busy), 1);
        @(negedge clk); chk("t4_busy_after_pop", int'(busy), 0);
        tick();
        drain();
        chk("t4_writes", n_writes - w0, 9);

        // Reset in the middle of a stalled write
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) plot(1 + i, 1, 3);
        chk("t5_wren_before", int'(mem_wren), 1);
        chk("t5_pending_before", int'(pending), 4);
        #2 reset = 1'b1;
        #1;
        chk("t5_wren_async", int'(mem_wren), 0);
        chk("t5_pending_async", int'(pending), 0);
        chk("t5_clip_async", int'(clip_count), 0);
        tick();
        reset = 1'b0;
        mem_ready = 1'b1;
        w0 = n_writes;
        repeat (10) tick();
        chk("t5_no_writes", n_writes - w0, 0);

        // Clip counter saturation
        x = 10'd200; y = 10'd5; colour = 3'd1; writeEn = 1'b1;
        repeat (65540) tick();
        writeEn = 1'b0;
        tick();
        chk("t6_clip_sat", int'(clip_count), 65535);
        chk("t6_ovf", int'(overflow_count), 0);
        chk("t6_pending", int'(pending), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/plot_receiver.md
Name: plot_receiver

Overview:
- Receiving end of the pixel-plot interface (x, y, colour, writeEn) that the draw multiplexer drives.
- Buffers plot requests in a small FIFO and clips them to the screen.
- Converts each (x, y) to a linear framebuffer address (y*SCREEN_W + x) and writes it to a single-port pixel memory using a write/ready handshake.
- Sits between the draw multiplexer and the framebuffer store. Reports backpressure, clip and overflow statistics for debug LEDs.

Parameters:
- SCREEN_W, 160, visible width in pixels; x >= SCREEN_W is clipped
- SCREEN_H, 120, visible height in pixels; y >= SCREEN_H is clipped
- FIFO_DEPTH, 8, plot FIFO entries (power of two)
- ADDR_W, 15, framebuffer address width (must cover SCREEN_W*SCREEN_H-1)
- COLOUR_W, 3, colour bits per pixel

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- x  input  10  plot x coordinate
- y  input  10  plot y coordinate
- colour  input  COLOUR_W  plot colour
- writeEn  input  1  plot strobe, one pixel per cycle high
- busy  output  1  FIFO full; plots offered this cycle are dropped
- mem_address  output  ADDR_W  framebuffer write address
- mem_data  output  COLOUR_W  framebuffer write data
- mem_wren  output  1  write request, held until mem_ready
- mem_ready  input  1  memory accepts write in this cycle when mem_wren=1
- pending  output  4  FIFO occupancy plus 1 if a pixel is held in the pipeline
- clip_count  output  16  saturating count of clipped plots
- overflow_count  output  16  saturating count of plots dropped because FIFO full

Behaviour:
- Reset values: FIFO empty, FSM=IDLE, mem_wren=0, mem_address=0, mem_data=0, busy=0, pending=0, both counters 0.
- Reset takes effect asynchronously mid-write. mem_wren falls without waiting for mem_ready. The in-flight pixel and all queued pixels are discarded.

Intake, evaluated at each rising edge where writeEn=1:
- If x>=SCREEN_W or y>=SCREEN_H: not pushed; clip_count++ (saturates at 16'hFFFF). Clipping takes priority over overflow; a clipped plot never counts as overflow.
- Else, if FIFO full, judged before any same-cycle pop: not pushed; overflow_count++ (saturates).
- Else: {x[8:0] truncated to needed bits, y, colour} pushed.
- busy = FIFO full (combinational from occupancy).
- A simultaneous push and pop on a non-full FIFO leaves occupancy unchanged.

Drain FSM, states IDLE, ADDR, WRITE:
- IDLE: if FIFO non-empty, pop head into hold register and go to ADDR; else stay.
- ADDR: register mem_address = y*SCREEN_W + x (ADDR_W bits, no wrap possible after clipping) and mem_data = colour; go to WRITE.
- WRITE: mem_wren=1; address and data stable.
  - If mem_ready=0: stay in WRITE.
  - If mem_ready=1 and FIFO non-empty: pop next into hold register and go to ADDR.
  - If mem_ready=1 and FIFO empty: go to IDLE.
- mem_wren=0 in IDLE and ADDR.

Timing and ordering:
- Latency: with FSM in IDLE and FIFO empty, a plot sampled at edge N produces mem_wren=1 between edges N+2 and N+3. With mem_ready=1 it is accepted at edge N+3.
- Sustained throughput is one pixel per 2 cycles.
- Writes leave in plot order; no reordering, no merging of duplicates.
- pending counts FIFO entries plus 1 while the FSM is in ADDR or WRITE. Maximum value is FIFO_DEPTH+1.

Test Plan:
- Reset, mem_ready=1, one plot (x=5, y=3, colour=3'b101) -> mem_wren high exactly 2 edges later for 1 cycle, mem_address=485, mem_data=5; pending returns to 0; counters 0.
- Plot (159,119,3'b010) then (0,0,3'b111) back-to-back, mem_ready=1 -> writes in order with addresses 19199 then 0; second mem_wren 2 cycles after the first.
- Plots (160,0) and (0,120) -> no mem_wren, clip_count=2, overflow_count=0; then (10,10) -> address 1610 written.
- mem_ready held 0, 10 back-to-back valid plots -> busy asserts, pending=9, overflow_count=1. Release mem_ready=1 -> exactly 9 writes in order, the 10th plot never written, busy falls after the first pop.
- mem_ready=0 with mem_wren=1 and 3 plots queued, assert reset for 1 cycle -> mem_wren=0 immediately (before next edge), pending=0, no further writes after reset release.
- Drive 65540 clipped plots -> clip_count saturates at 65535 and does not wrap.
